// File: rtl/stream_pipe_chain.sv
// Elastic valid/ready register pipeline with a per-word sequence tag, synchronous
// flush and a live occupancy count; bubbles collapse under downstream backpressure.
module stream_pipe_chain #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2,
    parameter int SEQ_W  = 4,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic [SEQ_W-1:0]  seq_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_rdy;
    logic [DATA_W-1:0] w_d [STAGES];
    logic [SEQ_W-1:0]  w_t [STAGES];
    logic              w_accept;
    logic [SEQ_W-1:0]  r_seq;

    assign ready_out = w_rdy[0] & ~flush;
    assign w_accept  = valid_in & ready_out;

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        logic              r_vld;
        logic [DATA_W-1:0] r_dat;
        logic [SEQ_W-1:0]  r_tag;
        logic              w_srcV;
        logic [DATA_W-1:0] w_srcD;
        logic [SEQ_W-1:0]  w_srcT;

        // A stage may load whenever it or any stage downstream of it has room.
        assign w_rdy[g] = ready_in | ~(&w_v[STAGES-1:g]);

        if (g == 0) begin : gSrcIn
            assign w_srcV = w_accept;
            assign w_srcD = data_in;
            assign w_srcT = r_seq;
        end else begin : gSrcPrev
            assign w_srcV = w_v[g-1];
            assign w_srcD = w_d[g-1];
            assign w_srcT = w_t[g-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_dat <= '0;
                r_tag <= '0;
            end else if (flush) begin
                r_vld <= 1'b0;
            end else if (w_rdy[g]) begin
                r_vld <= w_srcV;
                r_dat <= w_srcD;
                r_tag <= w_srcT;
            end
        end

        assign w_v[g] = r_vld;
        assign w_d[g] = r_dat;
        assign w_t[g] = r_tag;
    end

    // The tag counter survives flush so tags stay unique across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else if (w_accept) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    assign valid_out = w_v[STAGES-1];
    assign data_out  = w_d[STAGES-1];
    assign seq_out   = w_t[STAGES-1];
    assign occupancy = OCC_W'($countones(w_v));

endmodule

// File: tb/tb_stream_pipe_chain.sv
// Self-checking bench for stream_pipe_chain (DATA_W=8, STAGES=3, SEQ_W=4) using an
// in-flight word queue as the reference model.
module tb_stream_pipe_chain;

    localparam int DATA_W = 8;
    localparam int STAGES = 3;
    localparam int SEQ_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic [SEQ_W-1:0]  seq_out;
    logic              valid_out;
    logic              ready_in = 1'b0;
    logic [1:0]        occupancy;

    stream_pipe_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
        .seq_out(seq_out), .valid_out(valid_out), .ready_in(ready_in),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [SEQ_W-1:0]  t;
        int                acc;
    } word_t;

    word_t             q[$];
    logic [DATA_W-1:0] outLog[$];
    logic [SEQ_W-1:0]  seqLog[$];
    int                cycle = 0;
    int                checkCount = 0;
    int                passCount = 0;
    int                failCount = 0;
    logic [SEQ_W-1:0]  mSeq = '0;
    bit                lastAcc = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        #1;
    endtask

    // One clock cycle: compare DUT against the queue model mid-cycle, then advance the model.
    task automatic stepCycle();
        bit expRdy, expV, acc, xfer;
        @(negedge clk);
        expRdy = !flush && (ready_in || q.size() < STAGES);
        expV   = (q.size() > 0) && (cycle - q[0].acc >= STAGES);
        checkOutput("ready_out", {31'b0, ready_out}, {31'b0, expRdy});
        checkOutput("valid_out", {31'b0, valid_out}, {31'b0, expV});
        checkOutput("occupancy", 32'(occupancy), 32'(q.size()));
        if (expV) begin
            checkOutput("data_out", 32'(data_out), 32'(q[0].d));
            checkOutput("seq_out", 32'(seq_out), 32'(q[0].t));
        end
        acc  = valid_in && expRdy;
        xfer = expV && ready_in;
        if (xfer) begin
            outLog.push_back(data_out);
            seqLog.push_back(seq_out);
        end
        @(posedge clk);
        if (xfer) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else if (acc) begin
            q.push_back('{data_in, mSeq, cycle});
            mSeq++;
        end
        lastAcc = acc;
        cycle++;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        valid_in = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_seq_out", 32'(seq_out), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_ready_out", {31'b0, ready_out}, 32'd1);
        q.delete();
        mSeq = '0;
        outLog.delete();
        seqLog.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DATA_W-1:0] nextD;
        logic [DATA_W-1:0] curD;
        bit                curV;
        int                sent;

        // Single word latency.
        doReset();
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t1_valid_lat3", {31'b0, valid_out}, 32'd1);
        checkOutput("t1_data", 32'(data_out), 32'hA5);
        checkOutput("t1_seq", 32'(seq_out), 32'd0);
        stepCycle();
        checkOutput("t1_occ_empty", 32'(occupancy), 32'd0);

        // Back-to-back stream with tag wrap.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
            checkOutput("t2_ready", {31'b0, ready_out}, 32'd1);
            stepCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("t2_count", 32'(outLog.size()), 32'd20);
        for (int k = 0; k < outLog.size(); k++) begin
            checkOutput("t2_order", 32'(outLog[k]), 32'(k));
            checkOutput("t2_tag", 32'(seqLog[k]), 32'(k % 16));
        end

        // Backpressure fill and release.
        doReset();
        nextD = 8'h40;
        sent  = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, nextD, 1'b0, 1'b0);
            stepCycle();
            if (lastAcc) begin
                nextD++;
                sent++;
            end
        end
        applyStimulus(1'b1, nextD, 1'b0, 1'b0);
        checkOutput("t3_ready_low", {31'b0, ready_out}, 32'd0);
        checkOutput("t3_occ_full", 32'(occupancy), 32'd3);
        checkOutput("t3_data_held", 32'(data_out), 32'h40);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(sent < 6, nextD, 1'b1, 1'b0);
            stepCycle();
            if (lastAcc) begin
                nextD++;
                sent++;
            end
        end
        checkOutput("t3_count", 32'(outLog.size()), 32'd6);
        for (int k = 0; k < outLog.size(); k++) begin
            checkOutput("t3_order", 32'(outLog[k]), 32'(8'h40 + k));
        end

        // Flush with two words in flight and a word offered.
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t4_occ2", 32'(occupancy), 32'd2);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        checkOutput("t4_ready_flush", {31'b0, ready_out}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t4_occ_flushed", 32'(occupancy), 32'd0);
        applyStimulus(1'b1, 8'h88, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("t4_count", 32'(outLog.size()), 32'd1);
        if (outLog.size() > 0) begin
            checkOutput("t4_data", 32'(outLog[0]), 32'h88);
            checkOutput("t4_tag", 32'(seqLog[0]), 32'd2);
        end

        // Random traffic against the model.
        doReset();
        curV = 1'b0;
        curD = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!(curV && !lastAcc)) begin
                curV = ($urandom_range(0, 3) != 0);
                curD = 8'($urandom);
            end
            applyStimulus(curV, curD, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            stepCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) stepCycle();
        checkOutput("t5_occ_drained", 32'(occupancy), 32'd0);
        checkOutput("t5_valid_drained", {31'b0, valid_out}, 32'd0);

        // Asynchronous reset mid-stream.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        stepCycle();
        doReset();
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("t6_count", 32'(outLog.size()), 32'd1);
        if (outLog.size() > 0) begin
            checkOutput("t6_data", 32'(outLog[0]), 32'h5A);
            checkOutput("t6_tag", 32'(seqLog[0]), 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
